// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared command-byte layout and decoder state encoding
package pwm_pkg;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_HI_BIT   = 6;
  localparam int CMD_ADDR_LSB = 0;
  localparam int REG_ADDR_W   = 6;

  typedef enum logic [1:0] {
    CMD,
    RD_REQ,
    RD_CAP,
    DATA
  } instr_state_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - turns SPI command+data byte pairs into register read/write strobes
module instr_decoder
  import pwm_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic              hi_sel,
  output logic [7:0]        data_write,
  input  logic [7:0]        data_read
);

  instr_state_t      state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hi_sel_q, hi_sel_d;
  logic [7:0]        data_write_q, data_write_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              read_q, read_d;
  logic              write_q, write_d;

  always_comb begin
    state_d      = state_q;
    is_wr_d      = is_wr_q;
    addr_d       = addr_q;
    hi_sel_d     = hi_sel_q;
    data_write_d = data_write_q;
    data_out_d   = data_out_q;
    read_d       = 1'b0;
    write_d      = 1'b0;

    // Deselect abandons whatever pair is in flight; latched outputs keep their values.
    if (cs_n) begin
      state_d = CMD;
    end else begin
      case (state_q)
        CMD: begin
          if (byte_sync) begin
            is_wr_d  = data_in[CMD_RW_BIT];
            hi_sel_d = data_in[CMD_HI_BIT];
            addr_d   = data_in[CMD_ADDR_LSB +: ADDR_W];
            read_d   = ~data_in[CMD_RW_BIT];
            state_d  = data_in[CMD_RW_BIT] ? DATA : RD_REQ;
          end
        end
        RD_REQ: state_d = RD_CAP;
        RD_CAP: begin
          data_out_d = data_read;
          state_d    = DATA;
        end
        DATA: begin
          if (byte_sync) begin
            if (is_wr_q) begin
              write_d      = 1'b1;
              data_write_d = data_in;
            end
            state_d = CMD;
          end
        end
        default: state_d = CMD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CMD;
      is_wr_q      <= 1'b0;
      addr_q       <= '0;
      hi_sel_q     <= 1'b0;
      data_write_q <= 8'h00;
      data_out_q   <= 8'h00;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_wr_q      <= is_wr_d;
      addr_q       <= addr_d;
      hi_sel_q     <= hi_sel_d;
      data_write_q <= data_write_d;
      data_out_q   <= data_out_d;
      read_q       <= read_d;
      write_q      <= write_d;
    end
  end

  assign data_out   = data_out_q;
  assign read       = read_q;
  assign write      = write_q;
  assign addr       = addr_q;
  assign hi_sel     = hi_sel_q;
  assign data_write = data_write_q;

endmodule

// File: tb/tb_instr_decoder.sv
// tb/tb_instr_decoder.sv - directed and randomized checks of instr_decoder against a transaction model
module tb_instr_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       byte_sync = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic       hi_sel;
  logic [7:0] data_write;
  logic [7:0] data_read = 8'h00;

  int total = 0;
  int bad = 0;
  int both_cnt = 0;

  logic [7:0]  rf [128];
  logic [14:0] exp_w [$];
  logic [14:0] got_w [$];
  logic [6:0]  exp_r [$];
  logic [6:0]  got_r [$];
  logic [7:0]  exp_dout = 8'h00;

  instr_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .cs_n       (cs_n),
    .byte_sync  (byte_sync),
    .data_in    (data_in),
    .data_out   (data_out),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .hi_sel     (hi_sel),
    .data_write (data_write),
    .data_read  (data_read)
  );

  always #5 clk = ~clk;

  // Register file: answers a read strobe with the addressed byte on the next cycle.
  always @(posedge clk) data_read <= read ? rf[{hi_sel, addr}] : 8'h00;

  always @(negedge clk) begin
    if (write) got_w.push_back({hi_sel, addr, data_write});
    if (read) got_r.push_back({hi_sel, addr});
    if (read && write) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [7:0] b);
    byte_sync = 1'b1;
    data_in   = b;
    tick();
    byte_sync = 1'b0;
  endtask

  task automatic expect_cmd(input logic [7:0] cmd);
    if (!cmd[7]) begin
      exp_r.push_back(cmd[6:0]);
      exp_dout = rf[cmd[6:0]];
    end
  endtask

  task automatic pair(input logic [7:0] cmd, input logic [7:0] dat);
    pulse(cmd);
    idle(4);
    pulse(dat);
    idle(3);
    expect_cmd(cmd);
    if (cmd[7]) exp_w.push_back({cmd[6:0], dat});
  endtask

  initial begin
    logic [7:0] cmd, dat;
    logic [7:0] addr_before, dout_before;
    int nw, nr;

    for (int i = 0; i < 128; i++) rf[i] = 8'($urandom);
    rf[5] = 8'hA7;

    idle(3);
    check("rst_data_out", data_out, 0);
    check("rst_addr", addr, 0);
    check("rst_hi_sel", hi_sel, 0);
    check("rst_data_write", data_write, 0);
    check("rst_strobes", {read, write}, 0);
    rst = 1'b0;
    idle(2);
    cs_n = 1'b0;
    idle(2);

    // Write 0xC3, 0x5A with exact strobe timing.
    pulse(8'hC3);
    check("wr_addr_T1", {hi_sel, addr}, {1'b1, 6'h03});
    idle(4);
    pulse(8'h5A);
    check("wr_strobe_D1", {read, write}, 2'b01);
    check("wr_fields_D1", {hi_sel, addr, data_write}, {1'b1, 6'h03, 8'h5A});
    tick();
    check("wr_strobe_D2", write, 0);
    idle(2);
    exp_w.push_back({7'h43, 8'h5A});

    // Read 0x05 with exact strobe and capture timing.
    pulse(8'h05);
    check("rd_strobe_T1", {read, write}, 2'b10);
    check("rd_addr_T1", {hi_sel, addr}, {1'b0, 6'h05});
    tick();
    check("rd_strobe_T2", read, 0);
    tick();
    check("rd_data_out_T3", data_out, 8'hA7);
    idle(2);
    pulse(8'h00);
    idle(3);
    expect_cmd(8'h05);
    check("rd_data_out_hold", data_out, 8'hA7);

    // Abort: write command, then deselect before the data byte.
    nw = got_w.size();
    pulse(8'h81);
    idle(3);
    cs_n = 1'b1;
    idle(2);
    pulse(8'h99);
    idle(2);
    cs_n = 1'b0;
    idle(2);
    check("abort_no_write", got_w.size(), nw);
    pair(8'h42, 8'h00);
    check("abort_next_is_cmd", data_out, rf[7'h42]);

    // Data byte and deselect in the same cycle: deselect wins.
    pulse(8'h8A);
    idle(3);
    cs_n = 1'b1;
    pulse(8'h66);
    idle(2);
    cs_n = 1'b0;
    idle(2);
    check("cs_wins_no_write", got_w.size(), nw);

    // Back-to-back pairs in one frame.
    pair(8'h81, 8'h11);
    pair(8'h82, 8'h22);
    check("b2b_count", got_w.size(), nw + 2);

    // Reset while waiting for write data.
    pulse(8'h81);
    idle(2);
    rst = 1'b1;
    tick();
    check("midrst_outputs", {data_out, addr, hi_sel, data_write, read, write}, 0);
    rst = 1'b0;
    exp_dout = 8'h00;
    idle(2);
    pair(8'hC5, 8'h77);
    check("midrst_back_in_cmd", got_w.size(), nw + 3);

    // Bytes while deselected are ignored.
    nw = got_w.size();
    nr = got_r.size();
    addr_before = {2'b00, addr};
    dout_before = data_out;
    cs_n = 1'b1;
    idle(2);
    pulse(8'h05);
    idle(3);
    pulse(8'h9C);
    idle(3);
    check("ign_strobes", {got_w.size(), got_r.size()}, {nw, nr});
    check("ign_addr", {2'b00, addr}, addr_before);
    check("ign_data_out", data_out, dout_before);
    cs_n = 1'b0;
    idle(2);

    // Randomized pairs, some aborted by deselect before the data byte.
    for (int k = 0; k < 40; k++) begin
      cmd = 8'($urandom);
      dat = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        pulse(cmd);
        idle(4);
        cs_n = 1'b1;
        pulse(dat);
        idle(2);
        cs_n = 1'b0;
        idle(2);
        expect_cmd(cmd);
      end else begin
        pair(cmd, dat);
      end
      check("rnd_data_out", data_out, exp_dout);
      check("rnd_write_cnt", got_w.size(), exp_w.size());
    end

    check("final_write_cnt", got_w.size(), exp_w.size());
    check("final_read_cnt", got_r.size(), exp_r.size());
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check("final_write_item", got_w[i], exp_w[i]);
    for (int i = 0; i < exp_r.size() && i < got_r.size(); i++)
      check("final_read_item", got_r[i], exp_r[i]);
    check("read_write_overlap", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
